ifetch: RTL and testbench

Instruction fetch stage of the LEGv8 core, directly upstream of the main decoder. It holds the fetch PC, issues requests to instruction memory over a split request/response interface, and buffers returned words with their PCs in a small FIFO. The FIFO head is presented to decode over a valid/ready handshake, and `instr[31:21]` drives the decoder's `Op` input. A taken branch redirects the PC, flushes the FIFO and discards any in-flight response.

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/ifetch_buffer.sv | 63 ++++++
 rtl/ifetch.sv | 151 +++++++++++++++
 tb/tb_ifetch.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [63:0] PC_STEP = 64'd4;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ifetch_buffer.sv
// Small power-of-two FIFO of fetched words with their PCs; flush empties it synchronously.
module ifetch_buffer
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  fetch_entry_t  i_entry,
    output logic [CW-1:0] o_count,
    output fetch_entry_t  o_head
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && (r_count != FULL_CNT);
    assign w_do_pop  = i_pop && (r_count != '0);

    // Storage, pointers and occupancy; flush overrides any same-cycle push or pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/ifetch.sv
// LEGv8 instruction fetch: PC, single-outstanding imem request FSM and decode-side FIFO.
// Optional IFETCH_PERF_CNT_EN adds saturating perf_fetched / perf_flushed counters.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        instr_ready
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int            CW        = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(BUF_DEPTH);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [63:0]   r_fetch_pc;
    logic [63:0]   r_req_pc;
    logic [63:0]   w_target;
    logic          w_req;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_entry;
    fetch_entry_t  w_head;

    assign w_target = branch_target & ~64'd3;

    // Next state and request/push decode; the free-slot check reserves room for the response.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                w_req = (w_count < DEPTH_CNT) && !branch_taken;
                if (w_req && imem_gnt) begin
                    w_state_nxt = WAIT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    w_push      = !branch_taken;
                    w_state_nxt = IDLE;
                end else if (branch_taken) begin
                    w_state_nxt = DROP;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DROP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign imem_req  = w_req && reset;
    assign imem_addr = r_fetch_pc;
    assign w_grant   = imem_req && imem_gnt;

    // State register, fetch PC and the PC of the request awaiting its response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= 64'd0;
        end else begin
            r_state <= w_state_nxt;
            if (branch_taken) begin
                r_fetch_pc <= w_target;
                r_req_pc   <= r_req_pc;
            end else if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
                r_req_pc   <= r_fetch_pc;
            end else begin
                r_fetch_pc <= r_fetch_pc;
                r_req_pc   <= r_req_pc;
            end
        end
    end

    assign w_pop         = instr_valid && instr_ready;
    assign w_entry.pc    = r_req_pc;
    assign w_entry.instr = imem_rdata;

    ifetch_buffer #(
        .DEPTH(BUF_DEPTH)
    ) u_buffer (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (branch_taken),
        .i_entry (w_entry),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign instr_valid = (w_count != '0);
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;
    logic        w_discard;

    // A redirect only counts when it throws away a buffered word or a live response.
    assign w_discard = branch_taken && ((w_count != '0) || (r_state == WAIT));

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_fetched <= 32'd0;
            r_perf_flushed <= 32'd0;
        end else begin
            r_perf_fetched <= w_push    ? sat_inc32(r_perf_fetched) : r_perf_fetched;
            r_perf_flushed <= w_discard ? sat_inc32(r_perf_flushed) : r_perf_flushed;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus random traffic against a queue model.
module tb_ifetch;

    localparam logic [63:0] RPC   = 64'h100;
    localparam int          DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    ifetch #(
        .RESET_PC (RPC),
        .BUF_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] w;
    } ent_t;

    int checks;
    int errors;

    // Model: decode-visible queue, fetch PC, and the single outstanding request.
    ent_t        q[$];
    logic [63:0] m_pc;
    bit          m_pend;
    bit          m_live;
    logic [63:0] m_pend_pc;
    logic [31:0] m_fetched;
    logic [31:0] m_flushed;

    // Memory responder: latency 1..3 (lat_sel 0 = random).
    bit          mem_busy;
    int          mem_lat;
    logic [31:0] mem_data;
    int          lat_sel;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] memw(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc      = RPC;
        m_pend    = 1'b0;
        m_live    = 1'b0;
        m_pend_pc = 64'd0;
        m_fetched = 32'd0;
        m_flushed = 32'd0;
        mem_busy  = 1'b0;
        mem_lat   = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        branch_taken = 1'b0;
        instr_ready  = 1'b0;
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, RPC);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 64'd0);
`ifdef IFETCH_PERF_CNT_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
        check("rst_perf_flushed", perf_flushed, 32'd0);
`endif
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One cycle: drive at negedge, compare #1 later, then advance the model to the next edge.
    task automatic step(input bit g, input bit r, input bit b, input logic [63:0] t, input bit stray);
        bit          rv;
        bit          mem_rv;
        bit          exp_req;
        bit          granted;
        @(negedge clk);
        mem_rv        = mem_busy && (mem_lat == 1);
        rv            = mem_rv || stray;
        imem_gnt      = g;
        instr_ready   = r;
        branch_taken  = b;
        branch_target = t;
        imem_rvalid   = rv;
        imem_rdata    = mem_rv ? mem_data : $urandom;
        #1;
        exp_req = !m_pend && (q.size() < DEPTH) && !b;
        check("imem_req", imem_req, exp_req);
        check("imem_addr", imem_addr, m_pc);
        check("instr_valid", instr_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("instr", instr, q[0].w);
            check("instr_pc", instr_pc, q[0].pc);
        end
`ifdef IFETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_flushed", perf_flushed, m_flushed);
`endif
        granted = exp_req && g;
        if (mem_rv) mem_busy = 1'b0;
        else if (mem_busy) mem_lat--;
        if (granted) begin
            mem_busy = 1'b1;
            mem_lat  = (lat_sel == 0) ? int'($urandom_range(1, 3)) : lat_sel;
            mem_data = memw(m_pc);
        end
        if (b) begin
            if (q.size() != 0 || (m_pend && m_live)) m_flushed = sat(m_flushed);
            q.delete();
            if (m_pend && rv) m_pend = 1'b0;
            else if (m_pend) m_live = 1'b0;
            m_pc = {t[63:2], 2'b00};
        end else begin
            if (r && q.size() != 0) void'(q.pop_front());
            if (m_pend && rv) begin
                if (m_live) begin
                    q.push_back('{pc: m_pend_pc, w: imem_rdata});
                    m_fetched = sat(m_fetched);
                end
                m_pend = 1'b0;
            end
            if (granted) begin
                m_pend    = 1'b1;
                m_live    = 1'b1;
                m_pend_pc = m_pc;
                m_pc      = m_pc + 64'd4;
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'd0;
        branch_taken  = 1'b0;
        branch_target = 64'd0;
        instr_ready   = 1'b0;
        lat_sel       = 1;
        model_reset();

        // Streaming with 1-cycle memory: one word per two cycles from RESET_PC.
        do_reset();
        repeat (8) step(1'b1, 1'b1, 1'b0, 64'd0, 1'b0);

        // Backpressure: two entries fill, requests stop, then drain and resume.
        do_reset();
        repeat (8) step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        repeat (8) step(1'b1, 1'b1, 1'b0, 64'd0, 1'b0);

        // Redirect to 0x2003 while a 3-cycle response is pending.
        do_reset();
        lat_sel = 3;
        step(1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 64'h2003, 1'b0);
        repeat (12) step(1'b1, 1'b1, 1'b0, 64'd0, 1'b0);

        // Redirect coinciding with response and pop while one entry is buffered.
        do_reset();
        lat_sel = 2;
        repeat (5) step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 64'h4000, 1'b0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 64'd0, 1'b0);

        // PC wrap at the top of the address space.
        do_reset();
        lat_sel = 1;
        step(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 64'd0, 1'b0);

        // Reset mid-request, then a stray response in IDLE must be ignored.
        step(1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
        do_reset();
        step(1'b0, 1'b1, 1'b0, 64'd0, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0, 64'd0, 1'b0);

        // Three pushes, then a redirect while a request is outstanding.
        do_reset();
        lat_sel = 1;
        repeat (7) step(1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 64'h3000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
`ifdef IFETCH_PERF_CNT_EN
        check("perf_fetched_3", perf_fetched, 32'd3);
        check("perf_flushed_1", perf_flushed, 32'd1);
`endif

        // Random traffic.
        do_reset();
        lat_sel = 0;
        repeat (3000) begin
            step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 12) == 0,
                 {$urandom, $urandom}, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
